// File: rtl/btn_click_decoder.sv
// Resynchronises a debounced button pulse, classifies presses as single/double
// clicks and hands events out over valid/ready. Optional macro: BTN_CLICK_PRESS_CNT_EN.
module btn_click_decoder #(
  parameter int unsigned WINDOW_CYCLES = 25000000,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  output logic       evt_valid,
  output logic       evt_double,
  input  logic       evt_ready,
  output logic       ovr_flag,
  input  logic       ovr_clr,
  output logic [7:0] press_count
);

  localparam int unsigned TW = $clog2(WINDOW_CYCLES);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(WINDOW_CYCLES - 1);

  typedef enum logic {
    IDLE,
    WAIT2
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise;
  state_e                 state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   gen_evt, gen_double;
  logic                   valid_q, valid_d;
  logic                   double_q, double_d;
  logic                   ovr_q, ovr_d;

  // btn_in is asynchronous, so it only enters the design through this chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      valid_q  <= 1'b0;
      double_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      valid_q  <= valid_d;
      double_q <= double_d;
      ovr_q    <= ovr_d;
    end
  end

  // A second press wins even on the timer==0 cycle, so rise is tested first
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    gen_evt    = 1'b0;
    gen_double = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = WAIT2;
          timer_d = TIMER_LOAD;
        end
      end
      WAIT2: begin
        if (rise) begin
          gen_evt    = 1'b1;
          gen_double = 1'b1;
          state_d    = IDLE;
        end else if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else begin
          gen_evt = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // New events may replace an event that is being accepted this cycle;
  // otherwise a held event is never disturbed and the newcomer is dropped.
  always_comb begin
    valid_d  = valid_q;
    double_d = double_q;
    ovr_d    = ovr_q;
    if (gen_evt && (!valid_q || evt_ready)) begin
      valid_d  = 1'b1;
      double_d = gen_double;
    end else if (valid_q && evt_ready) begin
      valid_d = 1'b0;
    end
    if (gen_evt && valid_q && !evt_ready) begin
      ovr_d = 1'b1;
    end else if (ovr_clr) begin
      ovr_d = 1'b0;
    end
  end

  assign evt_valid  = valid_q;
  assign evt_double = double_q;
  assign ovr_flag   = ovr_q;

`ifdef BTN_CLICK_PRESS_CNT_EN
  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (rise && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign press_count = count_q;
`else
  assign press_count = 8'd0;
`endif

endmodule

// File: doc/btn_click_decoder.md
Name: btn_click_decoder

Overview:
- Sits directly downstream of the push-button debouncer and consumes its cleaned pulse output.
- Resynchronises that pulse into the `clk` domain and detects rising edges.
- Classifies presses as single-click or double-click using a programmable time window.
- Presents each classified event to the control logic over a valid/ready handshake, with a sticky overrun flag.

Parameters:
- WINDOW_CYCLES, 25000000, double-click window in `clk` cycles (250 ms at 100 MHz); legal range is 2 or more.
- SYNC_STAGES, 2, length of the input synchroniser chain; legal range is 2 or more.

Ports:
- clk  input  1  system clock (100 MHz).
- rst_n  input  1  asynchronous active-low reset; clears all state immediately.
- btn_in  input  1  debounced press pulse from the debouncer; asynchronous to `clk` and held high for many cycles.
- evt_valid  output  1  a classified event is pending.
- evt_double  output  1  event type, valid while `evt_valid` is high: 1 = double-click, 0 = single-click.
- evt_ready  input  1  consumer accepts the event on the edge where `evt_valid` and `evt_ready` are both 1.
- ovr_flag  output  1  sticky: an event was dropped because the output register was occupied.
- ovr_clr  input  1  synchronous clear of `ovr_flag`.
- press_count  output  8  number of detected rising edges (see Optional Feature).

Behaviour:
- Reset:
  - Synchroniser flops, edge register, timer, `evt_valid`, `evt_double`, `ovr_flag` and `press_count` all go to 0.
  - FSM goes to IDLE.
- Synchroniser and edge detect:
  - `btn_in` passes through a SYNC_STAGES-deep flop chain. `sync` is the last stage; `prev` is `sync` delayed one cycle.
  - `rise = sync & ~prev`, one cycle wide per press.
  - A button held high across reset release yields one `rise`; it counts as a press.
- Timer width is `$clog2(WINDOW_CYCLES)`.
- FSM states are IDLE and WAIT2. Transitions:
  - IDLE, `rise`: load timer with WINDOW_CYCLES-1 and go to WAIT2.
  - WAIT2, `rise`: generate a double event and go to IDLE; this applies at any timer value, including 0.
  - WAIT2, no `rise`, timer != 0: decrement the timer.
  - WAIT2, no `rise`, timer == 0: generate a single event and go to IDLE.
  - A further `rise` after a double event starts a new sequence from IDLE.
- Timing:
  - The FSM enters WAIT2 at edge E0.
  - A single event is generated at edge E0+WINDOW_CYCLES.
  - A second `rise` sampled at any edge from E0+1 through E0+WINDOW_CYCLES produces a double event.
- Latency (SYNC_STAGES=2):
  - For a double event, `evt_valid` rises after the third `clk` edge, counting from the edge that first samples the second press high.
- Output register:
  - A generated event loads `evt_valid=1` and `evt_double`, but only if the register is free or being accepted in the same cycle (`evt_valid & evt_ready`).
  - If `evt_valid=1` and `evt_ready=0`, the new event is dropped, the held event is unchanged, and `ovr_flag` is set to 1.
  - Acceptance with no new event: `evt_valid` goes to 0 on the next edge.
  - `evt_valid`/`evt_double` must not change while stalled.
- `ovr_flag`:
  - `ovr_clr` clears it on the next edge.
  - If a set and `ovr_clr` occur in the same cycle, set wins.
- Reset asserted mid-window or with an event pending: the event is lost and no event is emitted after release, except a held button per the edge-detect rule.

Optional Feature:
- Macro: `BTN_CLICK_PRESS_CNT_EN`.
- Defined:
  - `press_count` increments by 1 on every `rise`, regardless of FSM state or output stall.
  - It saturates at 255 and has no wrap.
  - It is cleared only by reset.
- Undefined: `press_count` is tied to 8'd0, and no counter logic is synthesised.

Test Plan:
- WINDOW_CYCLES=20, one `btn_in` pulse of 10 cycles, `evt_ready`=1:
  - one event with `evt_double`=0.
  - `evt_valid` is high for exactly 1 cycle, 20 edges after the FSM enters WAIT2.
- Two pulses with rising edges 12 cycles apart:
  - one event with `evt_double`=1, arriving 3 edges after the second press is first sampled.
  - no single event follows.
- Second rise landing exactly on the timer==0 cycle: result is double; second rise one cycle later: result is single, and the FSM is back in WAIT2.
- Stall with `evt_ready`=0 holding a single event, then a double completes:
  - the held event stays single and `ovr_flag`=1.
  - raising `ovr_clr` clears `ovr_flag` on the next edge.
- `rst_n` pulsed low mid-window:
  - all outputs are 0 immediately (asynchronous), and no event is emitted afterwards.
  - with `btn_in` held high through release, exactly one `rise` and then a single event after the window.
- With `BTN_CLICK_PRESS_CNT_EN`:
  - 300 presses make `press_count` saturate at 255.
  - without the macro, `press_count` stays 0.
